rob_ring: RTL and testbench

Parametrised reorder buffer for the in-order-retire core. It sits between decode/issue and the register file, and allocates entries in program order through an internal tail pointer. It accepts out-of-order completions from `NUM_WB` writeback channels (ALU, cache/SB, MUL, …) and retires one entry per cycle from the head over a valid/ready handshake. Beyond the previous generation it adds:
- configurable depth, channel count and data width;
- an internal tail and true occupancy counter;
- an explicit commit handshake;
- a registered single-cycle flush on exception retire;
- youngest-first operand bypass with a "pending" indication.

---
 rtl/rob_pkg.sv | 30 +++
 rtl/rob_bypass_search.sv | 44 ++++
 rtl/rob_ring.sv | 186 ++++++++++++++++++
 tb/tb_rob_ring.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared types and constants for the reorder buffer: instruction classes,
// exception codes and the per-entry control record.
package rob_pkg;

  typedef enum logic [2:0] {
    IT_ALU    = 3'd0,
    IT_MUL    = 3'd1,
    IT_LOAD   = 3'd2,
    IT_STORE  = 3'd3,
    IT_BRANCH = 3'd4,
    IT_IRET   = 3'd5,
    IT_MOVRM  = 3'd6
  } instr_type_t;

  localparam logic [2:0] EXC_NONE     = 3'd0;
  localparam logic [2:0] EXC_ITLB     = 3'd1;
  localparam logic [2:0] EXC_DTLB     = 3'd2;
  localparam logic [2:0] EXC_ILLEGAL  = 3'd3;
  localparam logic [2:0] EXC_MISALIGN = 3'd4;

  // PC and result live in separate arrays since their width is a module parameter.
  typedef struct packed {
    logic        valid;
    logic        complete;
    logic [4:0]  rd;
    instr_type_t itype;
    logic [2:0]  exc;
  } rob_entry_t;

endpackage

// File: rtl/rob_bypass_search.sv
// Youngest-first operand search over the live ROB window, walking back from
// tail-1 for count entries; reports a completed hit or a pending producer.
module rob_bypass_search #(
  parameter int DEPTH = 16,
  parameter int XLEN  = 32,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]           ent_valid,
  input  logic [DEPTH-1:0]           ent_complete,
  input  logic [DEPTH-1:0][4:0]      ent_rd,
  input  logic [DEPTH-1:0][XLEN-1:0] ent_value,
  input  logic [IDX_W-1:0]           tail,
  input  logic [IDX_W:0]             count,
  input  logic [4:0]                 rs,
  output logic                       hit,
  output logic                       pending,
  output logic [XLEN-1:0]            value
);

  always_comb begin
    int               pos;
    logic [IDX_W-1:0] p;
    logic             found;
    hit     = 1'b0;
    pending = 1'b0;
    value   = '0;
    found   = 1'b0;
    pos     = 0;
    p       = '0;
    // Bounding the walk by count keeps it inside head..tail-1 without a head compare.
    for (int k = 1; k <= DEPTH; k++) begin
      pos = int'(tail) - k;
      if (pos < 0) pos = pos + DEPTH;
      p = IDX_W'(pos);
      if (!found && rs != 5'd0 && k <= int'(count) && ent_valid[p] && ent_rd[p] == rs) begin
        found   = 1'b1;
        hit     = ent_complete[p];
        pending = !ent_complete[p];
        if (ent_complete[p]) value = ent_value[p];
      end
    end
  end

endmodule

// File: rtl/rob_ring.sv
// Reorder buffer: in-order allocate at tail, out-of-order writeback, in-order
// commit from head, single-cycle flush after an excepting instruction retires.
module rob_ring
  import rob_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int NUM_WB = 3,
  parameter int XLEN   = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_alloc_valid,
  output logic              out_alloc_ready,
  input  logic [XLEN-1:0]   in_alloc_pc,
  input  logic [4:0]        in_alloc_rd,
  input  instr_type_t       in_alloc_type,
  output logic [IDX_W-1:0]  out_alloc_idx,
  input  logic              in_wb_valid [NUM_WB],
  input  logic [IDX_W-1:0]  in_wb_idx   [NUM_WB],
  input  logic [XLEN-1:0]   in_wb_value [NUM_WB],
  input  logic [2:0]        in_wb_exc   [NUM_WB],
  output logic              out_commit_valid,
  input  logic              in_commit_ready,
  output logic [XLEN-1:0]   out_commit_pc,
  output logic [XLEN-1:0]   out_commit_value,
  output logic [4:0]        out_commit_rd,
  output instr_type_t       out_commit_type,
  output logic [2:0]        out_commit_exc,
  output logic [IDX_W-1:0]  out_commit_idx,
  output logic              out_flush,
  input  logic [4:0]        in_src_rs       [2],
  output logic              out_src_hit     [2],
  output logic              out_src_pending [2],
  output logic [XLEN-1:0]   out_src_value   [2],
  output logic [IDX_W:0]    out_count,
  output logic              out_full,
  output logic              out_empty
);

  rob_entry_t        entry_reg [DEPTH];
  logic [XLEN-1:0]   pc_reg    [DEPTH];
  logic [XLEN-1:0]   value_reg [DEPTH];
  logic [IDX_W-1:0]  head_reg, tail_reg;
  logic [IDX_W:0]    count_reg;
  logic              flush_reg;

  rob_entry_t        head_ent;
  logic              alloc_fire, commit_fire, exc_fire;
  logic [NUM_WB-1:0] wb_hit [DEPTH];
  logic [DEPTH-1:0]           ent_valid, ent_complete;
  logic [DEPTH-1:0][4:0]      ent_rd;
  logic [DEPTH-1:0][XLEN-1:0] ent_value;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(DEPTH - 1)) ? '0 : p + IDX_W'(1);
  endfunction

  assign head_ent         = entry_reg[head_reg];
  assign out_full         = (count_reg == (IDX_W+1)'(DEPTH));
  assign out_empty        = (count_reg == '0);
  assign out_count        = count_reg;
  assign out_flush        = flush_reg;
  assign out_alloc_ready  = !out_full && !flush_reg;
  assign out_alloc_idx    = tail_reg;
  assign alloc_fire       = in_alloc_valid && out_alloc_ready;
  assign out_commit_valid = head_ent.valid && head_ent.complete;
  assign commit_fire      = out_commit_valid && in_commit_ready;
  assign exc_fire         = commit_fire && (head_ent.exc != EXC_NONE);

  always_comb begin
    out_commit_pc    = '0;
    out_commit_value = '0;
    out_commit_rd    = '0;
    out_commit_type  = IT_ALU;
    out_commit_exc   = '0;
    out_commit_idx   = '0;
    if (out_commit_valid) begin
      out_commit_pc    = pc_reg[head_reg];
      out_commit_value = value_reg[head_reg];
      out_commit_rd    = head_ent.rd;
      out_commit_type  = head_ent.itype;
      out_commit_exc   = head_ent.exc;
      out_commit_idx   = head_reg;
    end
  end

  // Writebacks only land on live entries and never during the flush cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wb_hit[i] = '0;
      for (int c = 0; c < NUM_WB; c++)
        wb_hit[i][c] = in_wb_valid[c] && (in_wb_idx[c] == IDX_W'(i)) &&
                       entry_reg[i].valid && !flush_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      flush_reg <= 1'b0;
    end else if (exc_fire) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      flush_reg <= 1'b1;
    end else begin
      flush_reg <= 1'b0;
      if (alloc_fire)  tail_reg <= wrap_inc(tail_reg);
      if (commit_fire) head_reg <= wrap_inc(head_reg);
      if (alloc_fire && !commit_fire)
        count_reg <= count_reg + (IDX_W+1)'(1);
      else if (!alloc_fire && commit_fire)
        count_reg <= count_reg - (IDX_W+1)'(1);
    end
  end

  // Channel loop runs low to high so the highest-numbered writer wins a collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entry_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (exc_fire) begin
          entry_reg[i].valid    <= 1'b0;
          entry_reg[i].complete <= 1'b0;
        end else begin
          for (int c = 0; c < NUM_WB; c++) begin
            if (wb_hit[i][c]) begin
              entry_reg[i].complete <= 1'b1;
              entry_reg[i].exc      <= in_wb_exc[c];
            end
          end
          if (commit_fire && head_reg == IDX_W'(i)) begin
            entry_reg[i].valid    <= 1'b0;
            entry_reg[i].complete <= 1'b0;
          end
          if (alloc_fire && tail_reg == IDX_W'(i)) begin
            entry_reg[i].valid    <= 1'b1;
            entry_reg[i].complete <= 1'b0;
            entry_reg[i].exc      <= EXC_NONE;
            entry_reg[i].rd       <= (in_alloc_type == IT_STORE) ? 5'd0 : in_alloc_rd;
            entry_reg[i].itype    <= in_alloc_type;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_fire && tail_reg == IDX_W'(i)) pc_reg[i] <= in_alloc_pc;
      for (int c = 0; c < NUM_WB; c++)
        if (wb_hit[i][c]) value_reg[i] <= in_wb_value[c];
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
    assign ent_valid[gi]    = entry_reg[gi].valid;
    assign ent_complete[gi] = entry_reg[gi].complete;
    assign ent_rd[gi]       = entry_reg[gi].rd;
    assign ent_value[gi]    = value_reg[gi];
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    rob_bypass_search #(
      .DEPTH(DEPTH),
      .XLEN (XLEN),
      .IDX_W(IDX_W)
    ) u_search (
      .ent_valid   (ent_valid),
      .ent_complete(ent_complete),
      .ent_rd      (ent_rd),
      .ent_value   (ent_value),
      .tail        (tail_reg),
      .count       (count_reg),
      .rs          (in_src_rs[gi]),
      .hit         (out_src_hit[gi]),
      .pending     (out_src_pending[gi]),
      .value       (out_src_value[gi])
    );
  end

endmodule

// File: tb/tb_rob_ring.sv
// Directed bench for rob_ring: a DEPTH=5 instance for most scenarios and a
// DEPTH=4 instance sharing the same stimulus for the full-buffer scenario.
module tb_rob_ring;
  import rob_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        alloc_valid = 1'b0;
  logic [31:0] alloc_pc = '0;
  logic [4:0]  alloc_rd = '0;
  instr_type_t alloc_type = IT_ALU;
  logic        wb_valid [3];
  logic [2:0]  wb_idx   [3];
  logic [1:0]  wb_idx4  [3];
  logic [31:0] wb_value [3];
  logic [2:0]  wb_exc   [3];
  logic        commit_ready = 1'b0;
  logic [4:0]  src_rs [2];

  logic        alloc_ready, commit_valid, flush, full, empty;
  logic [2:0]  alloc_idx, commit_idx, commit_exc;
  logic [31:0] commit_pc, commit_value;
  logic [4:0]  commit_rd;
  instr_type_t commit_type;
  logic        src_hit [2], src_pending [2];
  logic [31:0] src_value [2];
  logic [3:0]  count;

  logic        alloc_ready_4, commit_valid_4, flush_4, full_4, empty_4;
  logic [1:0]  alloc_idx_4, commit_idx_4;
  logic [2:0]  commit_exc_4;
  logic [31:0] commit_pc_4, commit_value_4;
  logic [4:0]  commit_rd_4;
  instr_type_t commit_type_4;
  logic        src_hit_4 [2], src_pending_4 [2];
  logic [31:0] src_value_4 [2];
  logic [2:0]  count_4;

  int n_checks = 0;
  int n_errors = 0;
  int seq   [7] = '{0, 1, 2, 3, 4, 0, 1};
  int vals6 [4] = '{32'h05, 32'h06, 32'h07, 32'h22};

  always #5 clk = ~clk;

  always_comb for (int g = 0; g < 3; g++) wb_idx4[g] = wb_idx[g][1:0];

  rob_ring #(.DEPTH(5), .NUM_WB(3), .XLEN(32)) u_dut (
    .clk(clk), .reset(reset),
    .in_alloc_valid(alloc_valid), .out_alloc_ready(alloc_ready),
    .in_alloc_pc(alloc_pc), .in_alloc_rd(alloc_rd), .in_alloc_type(alloc_type),
    .out_alloc_idx(alloc_idx),
    .in_wb_valid(wb_valid), .in_wb_idx(wb_idx), .in_wb_value(wb_value), .in_wb_exc(wb_exc),
    .out_commit_valid(commit_valid), .in_commit_ready(commit_ready),
    .out_commit_pc(commit_pc), .out_commit_value(commit_value), .out_commit_rd(commit_rd),
    .out_commit_type(commit_type), .out_commit_exc(commit_exc), .out_commit_idx(commit_idx),
    .out_flush(flush),
    .in_src_rs(src_rs), .out_src_hit(src_hit), .out_src_pending(src_pending),
    .out_src_value(src_value),
    .out_count(count), .out_full(full), .out_empty(empty)
  );

  rob_ring #(.DEPTH(4), .NUM_WB(3), .XLEN(32)) u_dut4 (
    .clk(clk), .reset(reset),
    .in_alloc_valid(alloc_valid), .out_alloc_ready(alloc_ready_4),
    .in_alloc_pc(alloc_pc), .in_alloc_rd(alloc_rd), .in_alloc_type(alloc_type),
    .out_alloc_idx(alloc_idx_4),
    .in_wb_valid(wb_valid), .in_wb_idx(wb_idx4), .in_wb_value(wb_value), .in_wb_exc(wb_exc),
    .out_commit_valid(commit_valid_4), .in_commit_ready(commit_ready),
    .out_commit_pc(commit_pc_4), .out_commit_value(commit_value_4), .out_commit_rd(commit_rd_4),
    .out_commit_type(commit_type_4), .out_commit_exc(commit_exc_4), .out_commit_idx(commit_idx_4),
    .out_flush(flush_4),
    .in_src_rs(src_rs), .out_src_hit(src_hit_4), .out_src_pending(src_pending_4),
    .out_src_value(src_value_4),
    .out_count(count_4), .out_full(full_4), .out_empty(empty_4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    if (alloc_valid && alloc_ready)
      $display("alloc  idx=%0d pc=0x%0h", alloc_idx, alloc_pc);
    if (commit_valid && commit_ready)
      $display("commit idx=%0d pc=0x%0h value=0x%0h exc=%0d", commit_idx, commit_pc, commit_value, commit_exc);
    @(negedge clk);
  endtask

  task automatic idle();
    alloc_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      wb_valid[c] = 1'b0;
      wb_idx[c]   = '0;
      wb_value[c] = '0;
      wb_exc[c]   = '0;
    end
  endtask

  task automatic set_wb(input int ch, input logic [2:0] idx, input logic [31:0] val, input logic [2:0] exc);
    wb_valid[ch] = 1'b1;
    wb_idx[ch]   = idx;
    wb_value[ch] = val;
    wb_exc[ch]   = exc;
  endtask

  task automatic alloc_one(input logic [31:0] pc, input logic [4:0] rd, input instr_type_t t);
    alloc_valid = 1'b1;
    alloc_pc    = pc;
    alloc_rd    = rd;
    alloc_type  = t;
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    commit_ready = 1'b0;
    src_rs[0] = '0;
    src_rs[1] = '0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    idle();
    src_rs[0] = '0;
    src_rs[1] = '0;
    #2 reset = 1'b1;
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ready", alloc_ready, 1);
    check("rst_flush", flush, 0);
    check("rst_commit_valid", commit_valid, 0);
    check("rst_commit_pc", commit_pc, 0);
    @(negedge clk);
    reset = 1'b0;

    // DEPTH=4: fill, refuse alloc while full even with a commit, drain in order
    do_reset();
    for (int i = 0; i < 4; i++) begin
      check("t1_alloc_idx", alloc_idx_4, i);
      check("t1_ready", alloc_ready_4, 1);
      alloc_one(32'h100 + i * 4, 5'(i + 1), IT_ALU);
    end
    check("t1_full", full_4, 1);
    check("t1_ready_full", alloc_ready_4, 0);
    check("t1_count_full", count_4, 4);
    check("t1_count5", count, 4);
    check("t1_full5", full, 0);
    for (int i = 0; i < 4; i++) begin
      set_wb(0, 3'(i), 32'h10 + i, EXC_NONE);
      step();
      idle();
    end
    commit_ready = 1'b1;
    alloc_valid  = 1'b1;
    alloc_pc     = 32'h999;
    for (int i = 0; i < 4; i++) begin
      check("t1_commit_valid", commit_valid_4, 1);
      check("t1_commit_idx", commit_idx_4, i);
      check("t1_commit_pc", commit_pc_4, 32'h100 + i * 4);
      check("t1_commit_value", commit_value_4, 32'h10 + i);
      step();
      alloc_valid = 1'b0;
      if (i == 0) check("t1_full_refuse", count_4, 3);
    end
    check("t1_empty", empty_4, 1);
    check("t1_count_end", count_4, 0);
    check("t1_commit_valid_end", commit_valid_4, 0);

    // DEPTH=5 wrap-around
    do_reset();
    for (int i = 0; i < 7; i++) begin
      check("t2_alloc_idx", alloc_idx, seq[i]);
      alloc_one(32'h200 + i, 5'd1, IT_ALU);
      set_wb(1, 3'(seq[i]), i, EXC_NONE);
      step();
      idle();
      commit_ready = 1'b1;
      check("t2_commit_valid", commit_valid, 1);
      check("t2_commit_pc", commit_pc, 32'h200 + i);
      check("t2_commit_idx", commit_idx, seq[i]);
      step();
      commit_ready = 1'b0;
    end
    check("t2_empty", empty, 1);

    // Out-of-order writeback: 2, then 0, then 1
    do_reset();
    for (int i = 0; i < 3; i++) alloc_one(32'h300 + i, 5'(i + 1), IT_LOAD);
    commit_ready = 1'b1;
    set_wb(0, 3'd2, 32'h32, EXC_NONE);
    step();
    idle();
    check("t3_wait", commit_valid, 0);
    set_wb(0, 3'd0, 32'h30, EXC_NONE);
    step();
    idle();
    check("t3_c0_valid", commit_valid, 1);
    check("t3_c0_idx", commit_idx, 0);
    set_wb(0, 3'd1, 32'h31, EXC_NONE);
    step();
    idle();
    check("t3_c1_valid", commit_valid, 1);
    check("t3_c1_idx", commit_idx, 1);
    check("t3_c1_value", commit_value, 32'h31);
    step();
    check("t3_c2_valid", commit_valid, 1);
    check("t3_c2_idx", commit_idx, 2);
    check("t3_c2_value", commit_value, 32'h32);
    step();
    check("t3_empty", empty, 1);
    commit_ready = 1'b0;

    // Exception on idx 1 flushes the already-complete idx 2
    do_reset();
    for (int i = 0; i < 3; i++) alloc_one(32'h400 + i, 5'(i + 1), IT_ALU);
    set_wb(0, 3'd2, 32'h42, EXC_NONE);
    set_wb(1, 3'd0, 32'h40, EXC_NONE);
    step();
    idle();
    set_wb(2, 3'd1, 32'h41, EXC_ITLB);
    step();
    idle();
    commit_ready = 1'b1;
    check("t4_c0_valid", commit_valid, 1);
    check("t4_c0_idx", commit_idx, 0);
    check("t4_c0_exc", commit_exc, 0);
    step();
    check("t4_c1_valid", commit_valid, 1);
    check("t4_c1_idx", commit_idx, 1);
    check("t4_c1_exc", commit_exc, 1);
    check("t4_c1_pc", commit_pc, 32'h401);
    check("t4_flush_early", flush, 0);
    step();
    check("t4_flush", flush, 1);
    check("t4_ready_flush", alloc_ready, 0);
    check("t4_no_commit", commit_valid, 0);
    check("t4_count_flush", count, 0);
    alloc_valid = 1'b1;
    alloc_pc    = 32'h4FF;
    step();
    alloc_valid = 1'b0;
    check("t4_flush_end", flush, 0);
    check("t4_ready_back", alloc_ready, 1);
    check("t4_count_end", count, 0);
    check("t4_empty", empty, 1);
    check("t4_no_commit2", commit_valid, 0);
    check("t4_tail_zero", alloc_idx, 0);
    commit_ready = 1'b0;

    // Bypass: youngest producer wins, STORE never matches
    do_reset();
    alloc_one(32'h500, 5'd5, IT_ALU);
    alloc_one(32'h504, 5'd5, IT_MUL);
    alloc_one(32'h508, 5'd5, IT_STORE);
    set_wb(0, 3'd0, 32'hAA, EXC_NONE);
    step();
    idle();
    src_rs[0] = 5'd5;
    src_rs[1] = 5'd0;
    #1;
    check("t5_pending", src_pending[0], 1);
    check("t5_hit_early", src_hit[0], 0);
    check("t5_value_early", src_value[0], 0);
    check("t5_rs0_hit", src_hit[1], 0);
    check("t5_rs0_pending", src_pending[1], 0);
    set_wb(1, 3'd1, 32'hBB, EXC_NONE);
    step();
    idle();
    src_rs[1] = 5'd7;
    #1;
    check("t5_hit", src_hit[0], 1);
    check("t5_pending_clr", src_pending[0], 0);
    check("t5_value", src_value[0], 32'hBB);
    check("t5_nomatch_hit", src_hit[1], 0);
    check("t5_nomatch_pending", src_pending[1], 0);

    // Same-index collision: channel 2 beats channel 0
    do_reset();
    for (int i = 0; i < 4; i++) alloc_one(32'h600 + i, 5'd1, IT_ALU);
    set_wb(0, 3'd3, 32'h11, EXC_NONE);
    set_wb(2, 3'd3, 32'h22, EXC_NONE);
    set_wb(1, 3'd0, 32'h05, EXC_NONE);
    step();
    idle();
    set_wb(0, 3'd1, 32'h06, EXC_NONE);
    set_wb(1, 3'd2, 32'h07, EXC_NONE);
    step();
    idle();
    commit_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t6_commit_idx", commit_idx, i);
      check("t6_commit_value", commit_value, vals6[i]);
      step();
    end
    check("t6_empty", empty, 1);
    commit_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
